// File: rtl/adex_pkg.sv
// Shared definitions for the AdEx neuron: reset-mode codes, FSM states and
// a saturating adder used by the adaptation datapath.
package adex_pkg;

    localparam int unsigned RESET_ZERO     = 0;
    localparam int unsigned RESET_SUBTRACT = 1;

    typedef enum logic {
        INTEG   = 1'b0,
        REFRACT = 1'b1
    } fsm_t;

    // Unsigned a + b, clipped to 2^width - 1 (width <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/adex_exp_term.sv
// Exponential upswing term of the AdEx membrane equation.
// Ports:
//   v      - current membrane potential
//   v_rheo - rheobase; term is zero at or below it
//   exp    - 1 << ((v - v_rheo) >> EXP_SHIFT), saturated to all ones
module adex_exp_term
    import adex_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EXP_SHIFT = 4
) (
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] v_rheo,
    output logic [WIDTH-1:0] exp
);

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sh;

    // Power-of-two approximation of exp(); shifts past the word saturate.
    always_comb begin
        exp  = '0;
        diff = '0;
        sh   = '0;
        if (v > v_rheo) begin
            diff = v - v_rheo;
            sh   = diff >> EXP_SHIFT;
            if (32'(sh) >= WIDTH) begin
                exp = '1;
            end else begin
                exp = WIDTH'(1) << sh;
            end
        end
    end

endmodule

// File: rtl/adex_neuron.sv
// Adaptive exponential integrate-and-fire neuron with shift leak,
// spike-triggered adaptation, refractory period and selectable reset mode.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - update enable; low holds all state, spike forced low
//   current     - synaptic input current
//   threshold   - firing threshold
//   v_rheo      - rheobase for the exponential term
//   spike       - one-cycle spike pulse (registered)
//   state       - membrane potential v (registered)
//   adapt       - adaptation variable w (registered)
//   refractory  - high while the neuron is refractory (registered)
module adex_neuron
    import adex_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned ADAPT_WIDTH    = 8,
    parameter int unsigned LEAK_SHIFT     = 3,
    parameter int unsigned EXP_SHIFT      = 4,
    parameter int unsigned ADAPT_B        = 16,
    parameter int unsigned TAU_W_SHIFT    = 4,
    parameter int unsigned REFRACT_CYCLES = 4,
    parameter int unsigned RESET_MODE     = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [WIDTH-1:0]       current,
    input  logic [WIDTH-1:0]       threshold,
    input  logic [WIDTH-1:0]       v_rheo,
    output logic                   spike,
    output logic [WIDTH-1:0]       state,
    output logic [ADAPT_WIDTH-1:0] adapt,
    output logic                   refractory
);

    // Headroom for v + current + exp (positive) and -w (negative).
    localparam int unsigned BASE_W = (WIDTH > ADAPT_WIDTH) ? WIDTH : ADAPT_WIDTH;
    localparam int unsigned RAW_W  = BASE_W + 3;
    localparam int unsigned CNT_W  = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

    fsm_t                   fsm_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [WIDTH-1:0]       exp_v;
    logic [RAW_W-1:0]       raw;
    logic [WIDTH-1:0]       vc;
    logic [WIDTH-1:0]       v_fire;
    logic                   fire;
    logic [ADAPT_WIDTH-1:0] w_dec;
    logic [ADAPT_WIDTH-1:0] w_spk;

    adex_exp_term #(
        .WIDTH     (WIDTH),
        .EXP_SHIFT (EXP_SHIFT)
    ) u_exp (
        .v      (state),
        .v_rheo (v_rheo),
        .exp    (exp_v)
    );

    // Membrane update with clamping to [0, 2^WIDTH-1], plus adaptation terms.
    always_comb begin
        raw = RAW_W'(state) - RAW_W'(state >> LEAK_SHIFT) + RAW_W'(current)
            + RAW_W'(exp_v) - RAW_W'(adapt);
        if (raw[RAW_W-1]) begin
            vc = '0;
        end else if (|raw[RAW_W-2:WIDTH]) begin
            vc = '1;
        end else begin
            vc = raw[WIDTH-1:0];
        end
        fire   = (vc >= threshold);
        v_fire = (RESET_MODE == RESET_SUBTRACT) ? (vc - threshold) : '0;
        // Decay first, then add the spike increment.
        w_dec  = adapt - (adapt >> TAU_W_SHIFT);
        w_spk  = ADAPT_WIDTH'(sat_add(32'(w_dec), 32'(ADAPT_B), ADAPT_WIDTH));
    end

    // FSM, refractory counter and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= INTEG;
            cnt_q      <= '0;
            state      <= '0;
            adapt      <= '0;
            spike      <= 1'b0;
            refractory <= 1'b0;
        end else if (!en) begin
            spike <= 1'b0;
        end else begin
            case (fsm_q)
                INTEG: begin
                    if (fire) begin
                        spike <= 1'b1;
                        state <= v_fire;
                        adapt <= w_spk;
                        if (REFRACT_CYCLES != 0) begin
                            fsm_q      <= REFRACT;
                            cnt_q      <= CNT_W'(REFRACT_CYCLES);
                            refractory <= 1'b1;
                        end
                    end else begin
                        spike <= 1'b0;
                        state <= vc;
                        adapt <= w_dec;
                    end
                end
                REFRACT: begin
                    spike <= 1'b0;
                    adapt <= w_dec;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        fsm_q      <= INTEG;
                        refractory <= 1'b0;
                    end
                end
                default: begin
                    fsm_q      <= INTEG;
                    refractory <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adex_neuron.sv
// Testbench for adex_neuron: two instances (reset-to-zero and subtract modes)
// share stimulus and are checked against an integer reference model.
module tb_adex_neuron;

    localparam int unsigned W     = 8;
    localparam int          LEAKD = 8;   // 2**LEAK_SHIFT
    localparam int          EXPD  = 16;  // 2**EXP_SHIFT
    localparam int          TAUD  = 16;  // 2**TAU_W_SHIFT
    localparam int          BINC  = 16;
    localparam int          NREF  = 4;
    localparam int          VMAX  = 255;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] current;
    logic [W-1:0] threshold;
    logic [W-1:0] v_rheo;

    logic         spike0, spike1, refr0, refr1;
    logic [W-1:0] state0, state1, adapt0, adapt1;

    logic         sp_a [2];
    logic         rf_a [2];
    logic [W-1:0] st_a [2];
    logic [W-1:0] ad_a [2];

    assign sp_a[0] = spike0;
    assign sp_a[1] = spike1;
    assign rf_a[0] = refr0;
    assign rf_a[1] = refr1;
    assign st_a[0] = state0;
    assign st_a[1] = state1;
    assign ad_a[0] = adapt0;
    assign ad_a[1] = adapt1;

    int n_tests;
    int n_fail;

    // Reference model: membrane, adaptation, remaining refractory cycles, spike.
    int mv   [2];
    int mw   [2];
    int mrem [2];
    bit msp  [2];

    adex_neuron #(.RESET_MODE(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .current    (current),
        .threshold  (threshold),
        .v_rheo     (v_rheo),
        .spike      (spike0),
        .state      (state0),
        .adapt      (adapt0),
        .refractory (refr0)
    );

    adex_neuron #(.RESET_MODE(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .current    (current),
        .threshold  (threshold),
        .v_rheo     (v_rheo),
        .spike      (spike1),
        .state      (state1),
        .adapt      (adapt1),
        .refractory (refr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i]   = 0;
            mw[i]   = 0;
            mrem[i] = 0;
            msp[i]  = 1'b0;
        end
    endtask

    // One enabled/disabled update of both model neurons with current inputs.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int e, raw, vc, sh;
            e = 0;
            if (!en) begin
                msp[i] = 1'b0;
            end else if (mrem[i] > 0) begin
                mrem[i] = mrem[i] - 1;
                mw[i]   = mw[i] - mw[i] / TAUD;
                msp[i]  = 1'b0;
            end else begin
                if (mv[i] > int'(v_rheo)) begin
                    sh = (mv[i] - int'(v_rheo)) / EXPD;
                    e  = (sh >= 8) ? VMAX : (1 << sh);
                end
                raw = mv[i] - mv[i] / LEAKD + int'(current) + e - mw[i];
                vc  = (raw < 0) ? 0 : ((raw > VMAX) ? VMAX : raw);
                if (vc >= int'(threshold)) begin
                    msp[i]  = 1'b1;
                    mv[i]   = (i == 1) ? vc - int'(threshold) : 0;
                    mw[i]   = mw[i] - mw[i] / TAUD + BINC;
                    if (mw[i] > VMAX) mw[i] = VMAX;
                    mrem[i] = NREF;
                end else begin
                    msp[i] = 1'b0;
                    mv[i]  = vc;
                    mw[i]  = mw[i] - mw[i] / TAUD;
                end
            end
        end
    endtask

    // Drive inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cycle(input bit e_in, input int cur, input int th, input int vr);
        en        = e_in;
        current   = W'(cur);
        threshold = W'(th);
        v_rheo    = W'(vr);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en    = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Held from time zero
        n_tests++;
        if (state0 !== 8'd0 || adapt0 !== 8'd0 || spike0 !== 1'b0 || refr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: got state=%0d adapt=%0d spike=%0d refr=%0d, expected all 0",
                     state0, adapt0, spike0, refr0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) cycle(1'b1, 40, 200, 255);
        n_tests++;
        if (refr0 !== 1'b1 || adapt0 !== 8'd16) begin
            n_fail++;
            $display("FAIL reset_pre_refract: got refr=%0d adapt=%0d, expected 1 16", refr0, adapt0);
        end
        // Asynchronous assertion mid-cycle, well away from any edge
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (state0 !== 8'd0 || adapt0 !== 8'd0 || spike0 !== 1'b0 || refr0 !== 1'b0 ||
            state1 !== 8'd0 || adapt1 !== 8'd0 || refr1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got s0=%0d a0=%0d sp0=%0d r0=%0d s1=%0d a1=%0d r1=%0d, expected all 0",
                     state0, adapt0, spike0, refr0, state1, adapt1, refr1);
        end
        en = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_tests++;
        if (refr0 !== 1'b0 || state0 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_release: got refr=%0d state=%0d, expected 0 0", refr0, state0);
        end
    endtask

    task automatic test_integration();
        int seq [7];
        seq = '{40, 75, 106, 133, 157, 178, 196};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, 40, 200, 255);
            n_tests++;
            if (state0 !== W'(seq[k]) || spike0 !== 1'b0) begin
                n_fail++;
                $display("FAIL integ_step%0d: got state=%0d spike=%0d, expected %0d 0",
                         k, state0, spike0, seq[k]);
            end
        end
        cycle(1'b1, 40, 200, 255);
        n_tests++;
        if (spike0 !== 1'b1 || state0 !== 8'd0 || adapt0 !== 8'd16 || refr0 !== 1'b1) begin
            n_fail++;
            $display("FAIL integ_spike: got spike=%0d state=%0d adapt=%0d refr=%0d, expected 1 0 16 1",
                     spike0, state0, adapt0, refr0);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 40, 200, 255);
            n_tests++;
            if (state0 !== 8'd0 || adapt0 !== 8'd15 || spike0 !== 1'b0 || refr0 !== (k < 3)) begin
                n_fail++;
                $display("FAIL refract_step%0d: got state=%0d adapt=%0d spike=%0d refr=%0d, expected 0 15 0 %0d",
                         k, state0, adapt0, spike0, refr0, (k < 3));
            end
        end
        cycle(1'b1, 40, 200, 255);
        n_tests++;
        if (state0 !== 8'd25 || refr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL integ_resume: got state=%0d refr=%0d, expected 25 0", state0, refr0);
        end
    endtask

    task automatic test_subtract();
        do_reset();
        for (int k = 0; k < 7; k++) cycle(1'b1, 40, 200, 255);
        cycle(1'b1, 40, 200, 255);
        n_tests++;
        if (spike1 !== 1'b1 || state1 !== 8'd12 || adapt1 !== 8'd16) begin
            n_fail++;
            $display("FAIL subtract_spike: got spike=%0d state=%0d adapt=%0d, expected 1 12 16",
                     spike1, state1, adapt1);
        end
    endtask

    task automatic test_threshold_zero();
        do_reset();
        cycle(1'b1, 0, 0, 255);
        n_tests++;
        if (spike0 !== 1'b1) begin
            n_fail++;
            $display("FAIL thr0_first: got spike=%0d, expected 1", spike0);
        end
        for (int k = 0; k < 4; k++) cycle(1'b1, 0, 0, 255);
        cycle(1'b1, 0, 0, 255);
        n_tests++;
        if (spike0 !== 1'b1 || refr0 !== 1'b1) begin
            n_fail++;
            $display("FAIL thr0_again: got spike=%0d refr=%0d, expected 1 1", spike0, refr0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        cycle(1'b1, 255, 255, 0);
        n_tests++;
        if (spike0 !== 1'b1 || state0 !== 8'd0 || spike1 !== 1'b1 || state1 !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_first: got sp0=%0d s0=%0d sp1=%0d s1=%0d, expected 1 0 1 0",
                     spike0, state0, spike1, state1);
        end
        for (int k = 0; k < 24; k++) begin
            cycle(1'b1, 250, 255, 0);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (st_a[i] !== W'(mv[i]) || ad_a[i] !== W'(mw[i]) || sp_a[i] !== msp[i]) begin
                    n_fail++;
                    $display("FAIL sat_exp dut%0d step%0d: got v=%0d w=%0d sp=%0d, expected %0d %0d %0d",
                             i, k, st_a[i], ad_a[i], sp_a[i], mv[i], mw[i], msp[i]);
                end
            end
        end
    endtask

    task automatic test_enable();
        logic [W-1:0] sv;
        logic [W-1:0] sw;
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, 40, 200, 255);
        sv = state0;
        sw = adapt0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 200, 0, 0);
            n_tests++;
            if (state0 !== sv || adapt0 !== sw || spike0 !== 1'b0) begin
                n_fail++;
                $display("FAIL en_hold%0d: got state=%0d adapt=%0d spike=%0d, expected %0d %0d 0",
                         k, state0, adapt0, spike0, sv, sw);
            end
        end
        // Freeze mid-refractory and check the remaining count survives
        for (int k = 0; k < 5; k++) cycle(1'b1, 40, 200, 255);
        for (int k = 0; k < 3; k++) cycle(1'b0, 40, 200, 255);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 40, 200, 255);
            n_tests++;
            if (state0 !== W'(mv[0]) || adapt0 !== W'(mw[0]) || spike0 !== msp[0] ||
                refr0 !== (mrem[0] > 0)) begin
                n_fail++;
                $display("FAIL en_resume%0d: got v=%0d w=%0d sp=%0d rf=%0d, expected %0d %0d %0d %0d",
                         k, state0, adapt0, spike0, refr0, mv[0], mw[0], msp[0], (mrem[0] > 0));
            end
        end
    endtask

    task automatic test_random();
        int cur, th, vr;
        bit e;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            e   = ($urandom_range(0, 99) < 85);
            cur = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 80);
            th  = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(60, 255);
            vr  = $urandom_range(0, 255);
            cycle(e, cur, th, vr);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (st_a[i] !== W'(mv[i]) || ad_a[i] !== W'(mw[i]) || sp_a[i] !== msp[i] ||
                    rf_a[i] !== (mrem[i] > 0)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got v=%0d w=%0d sp=%0d rf=%0d, expected %0d %0d %0d %0d",
                             i, k, st_a[i], ad_a[i], sp_a[i], rf_a[i], mv[i], mw[i], msp[i], (mrem[i] > 0));
                end
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        current   = '0;
        threshold = '0;
        v_rheo    = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_integration();
        test_subtract();
        test_threshold_zero();
        test_saturation();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
